// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot sequencer.
package uart_boot_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM, ST_RESP, ST_RUN
  } boot_state_e;

  localparam logic [7:0] BOOT_ACK = 8'h06;
  localparam logic [7:0] BOOT_NAK = 8'h15;
  localparam logic [7:0] DEF_SYNC = 8'hA5;
endpackage

// File: rtl/boot_word_asm.sv
// Assembles four received bytes into a little-endian word; word_done strobes
// combinationally with the 4th byte so the caller can latch word that cycle.
module boot_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word
);
  logic [1:0]  byte_idx;
  logic [23:0] shreg;

  assign word_done = byte_vld && !clr && (byte_idx == 2'd3);
  assign word      = {byte_in, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (clr) begin
      byte_idx <= '0;
      shreg    <= '0;
    end else if (byte_vld) begin
      byte_idx <= byte_idx + 2'd1;
      shreg    <= {byte_in, shreg[23:8]};
    end
  end
endmodule

// File: rtl/uart_boot_ctrl.sv
// UART boot sequencer: receives a framed image, writes it to program memory,
// answers ACK/NAK and releases the core reset on success.
module uart_boot_ctrl
  import uart_boot_pkg::*;
#(
  parameter int          MEM_SIZE    = 32*1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  output logic        core_rst,
  output logic        boot_done,
  output logic        boot_err
);
  localparam int MAX_WORDS = MEM_SIZE / 4;
  localparam int WCW       = $clog2(MAX_WORDS) + 1;
  localparam int TCW       = $clog2(TIMEOUT_CYC);

  boot_state_e    state, state_nxt;
  logic [15:0]    len;
  logic [WCW-1:0] widx;
  logic [7:0]     sum;
  logic [TCW-1:0] tmo_cnt;
  logic           csum_seen, csum_ok;
  logic           do_fail, do_ack, word_wr;
  logic           word_done;
  logic [31:0]    word;

  boot_word_asm u_asm (
    .clk       (clk_sys),
    .rst       (rst_sys),
    .clr       (state != ST_DATA),
    .byte_vld  (rx_valid),
    .byte_in   (rx_data),
    .word_done (word_done),
    .word      (word)
  );

  logic        tmo_active, tmo_hit, mem_busy, last_word, len_bad;
  logic [15:0] len_nxt;

  assign tmo_active = state inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
  // Fail on the cycle the idle count would reach TIMEOUT_CYC-1; a byte that
  // same cycle clears the counter instead.
  assign tmo_hit    = tmo_active && !rx_valid && (tmo_cnt == TCW'(TIMEOUT_CYC - 2));
  assign mem_busy   = mem_req && !mem_gnt;
  assign last_word  = (32'(widx) + 32'd1) == 32'(len);
  assign len_nxt    = {rx_data, len[7:0]};
  assign len_bad    = (len_nxt == 16'd0) || (32'(len_nxt) > 32'(MAX_WORDS));

  always_comb begin
    state_nxt = state;
    do_fail   = 1'b0;
    do_ack    = 1'b0;
    word_wr   = 1'b0;
    case (state)
      ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state_nxt = ST_LEN0;
      ST_LEN0: if (rx_valid) state_nxt = ST_LEN1;
               else if (tmo_hit) do_fail = 1'b1;
      ST_LEN1: if (rx_valid) begin
                 if (len_bad) do_fail = 1'b1;
                 else         state_nxt = ST_DATA;
               end else if (tmo_hit) do_fail = 1'b1;
      ST_DATA: if (word_done) begin
                 if (mem_busy) do_fail = 1'b1;
                 else begin
                   word_wr = 1'b1;
                   if (last_word) state_nxt = ST_CSUM;
                 end
               end else if (tmo_hit) do_fail = 1'b1;
      // Verdict waits until both the checksum byte and the last grant are in
      ST_CSUM: if ((csum_seen || rx_valid) && !mem_busy) begin
                 if (csum_seen ? csum_ok : (rx_data == sum)) do_ack  = 1'b1;
                 else                                        do_fail = 1'b1;
               end else if (tmo_hit) do_fail = 1'b1;
      ST_RESP: if (tx_ready) state_nxt = (tx_data == BOOT_ACK) ? ST_RUN : ST_IDLE;
      ST_RUN:  ;
      default: state_nxt = ST_IDLE;
    endcase
    if (do_fail || do_ack) state_nxt = ST_RESP;
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state     <= ST_IDLE;
      len       <= '0;
      widx      <= '0;
      sum       <= '0;
      tmo_cnt   <= '0;
      csum_seen <= 1'b0;
      csum_ok   <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      core_rst  <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= (rx_valid || !tmo_active) ? '0 : tmo_cnt + TCW'(1);

      if (state == ST_LEN0 && rx_valid) len[7:0]  <= rx_data;
      if (state == ST_LEN1 && rx_valid) len[15:8] <= rx_data;

      if (state == ST_LEN1) begin
        sum  <= '0;
        widx <= '0;
      end else if (state == ST_DATA && rx_valid) begin
        sum <= sum + rx_data;
        if (word_wr) widx <= widx + WCW'(1);
      end

      // A pending write always finishes, even after a NAK
      if (word_wr) begin
        mem_req   <= 1'b1;
        mem_wdata <= word;
        mem_addr  <= BASE_ADDR + (32'(widx) << 2);
      end else if (mem_gnt) begin
        mem_req <= 1'b0;
      end

      if (state != ST_CSUM) csum_seen <= 1'b0;
      else if (rx_valid && !csum_seen) begin
        csum_seen <= 1'b1;
        csum_ok   <= (rx_data == sum);
      end

      if (do_ack || do_fail) begin
        tx_valid <= 1'b1;
        tx_data  <= do_ack ? BOOT_ACK : BOOT_NAK;
      end else if (state == ST_RESP && tx_ready) begin
        tx_valid <= 1'b0;
      end

      if (do_fail) boot_err <= 1'b1;
      if (state == ST_RESP && state_nxt == ST_RUN) begin
        core_rst  <= 1'b0;
        boot_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Self-checking bench for uart_boot_ctrl: directed frames plus randomized
// frames checked against a frame-level reference model.
module tb_uart_boot_ctrl;
  import uart_boot_pkg::*;

  localparam int TMO = 100;

  logic        clk_sys = 1'b0, rst_sys = 1'b0;
  logic        rx_valid = 1'b0, tx_ready = 1'b0, mem_gnt = 1'b0;
  logic [7:0]  rx_data = '0, tx_data;
  logic        tx_valid, mem_req, core_rst, boot_done, boot_err;
  logic [31:0] mem_addr, mem_wdata;

  uart_boot_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .core_rst(core_rst), .boot_done(boot_done), .boot_err(boot_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef logic [7:0] bq_t[$];
  typedef wr_t wq_t[$];

  int  n_chk = 0, n_err = 0;
  wr_t wr_q[$];
  bit  gnt_hold = 0, gnt_rand = 0;
  int  gnt_w = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responder: decides the grant for the coming edge and logs the write
  always @(negedge clk_sys) begin
    if (rst_sys || !mem_req || gnt_hold) mem_gnt = 1'b0;
    else if (gnt_w > 0) begin mem_gnt = 1'b0; gnt_w--; end
    else begin
      mem_gnt = 1'b1;
      wr_q.push_back(wr_t'{mem_addr, mem_wdata});
      gnt_w = gnt_rand ? int'($urandom_range(0, 2)) : 0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_sys); rx_valid = 1'b1; rx_data = b;
    @(posedge clk_sys); #1 rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input bq_t q, input int maxgap);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(posedge clk_sys);
    end
  endtask

  // Reference model: frame bytes and the words it must produce at BASE_ADDR 0
  task automatic make_frame(input int n, input bit bad, output bq_t q, output wq_t exp);
    logic [7:0]  s, b;
    logic [31:0] w;
    logic [15:0] n16;
    q = {}; exp = {}; s = 0; n16 = 16'(n);
    q.push_back(8'hA5); q.push_back(n16[7:0]); q.push_back(n16[15:8]);
    for (int i = 0; i < n; i++) begin
      w = 0;
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom);
        q.push_back(b); s = s + b; w[8*k +: 8] = b;
      end
      exp.push_back(wr_t'{32'(4*i), w});
    end
    if (bad) s = s + 8'(1 + $urandom_range(0, 254));
    q.push_back(s);
  endtask

  task automatic get_resp(input string tag, output logic [7:0] d, output int lat);
    lat = 0;
    do begin @(negedge clk_sys); lat++; end while (!tx_valid && lat < 300);
    if (!tx_valid) begin chk({tag, "_tx_seen"}, 0, 1); d = 0; return; end
    d = tx_data;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk_sys);
      chk({tag, "_tx_hold"}, {tx_valid, tx_data}, {1'b1, d});
    end
    tx_ready = 1'b1;
    @(posedge clk_sys); #1 tx_ready = 1'b0;
  endtask

  task automatic check_writes(input string tag, input wq_t exp);
    chk({tag, "_nwr"}, wr_q.size(), exp.size());
    foreach (exp[i]) if (i < wr_q.size()) begin
      chk({tag, "_waddr"}, wr_q[i].a, exp[i].a);
      chk({tag, "_wdata"}, wr_q[i].d, exp[i].d);
    end
  endtask

  task automatic check_status(input string tag, input bit rst_e, input bit done_e, input bit err_e);
    chk({tag, "_status"}, {core_rst, boot_done, boot_err}, {rst_e, done_e, err_e});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx"},  {tx_valid, tx_data}, 9'h0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    check_status(tag, 1, 0, 0);
  endtask

  task automatic do_reset();
    rx_valid = 0; tx_ready = 0; gnt_hold = 0;
    @(negedge clk_sys); rst_sys = 1'b1;
    repeat (2) @(negedge clk_sys);
    rst_sys = 1'b0; wr_q.delete(); gnt_w = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t        q;
    wq_t        exp, exp1;
    logic [7:0] d;
    int         lat;
    bit         bad, exp_err;
    logic [7:0] g;

    // Reset state
    rst_sys = 1'b1; #1;
    check_reset_vals("rst");
    do_reset();

    // Bad lengths: NAK straight after LEN_HI, no memory traffic
    send_bytes('{8'hA5, 8'h00, 8'h00}, 0);
    get_resp("len0", d, lat);
    chk("len0_resp", d, BOOT_NAK); chk("len0_lat", lat, 1);
    send_bytes('{8'hA5, 8'h01, 8'h20}, 0);
    get_resp("lenbig", d, lat);
    chk("lenbig_resp", d, BOOT_NAK); chk("lenbig_lat", lat, 1);
    repeat (3) @(negedge clk_sys);
    chk("len_nwr", wr_q.size(), 0);
    check_status("len", 1, 0, 1);

    // Overrun: grant stalled while the second word arrives back-to-back
    make_frame(2, 0, q, exp);
    void'(q.pop_back());
    exp1 = {exp[0]};
    gnt_hold = 1;
    send_bytes(q, 0);
    chk("ovr_tx", {tx_valid, tx_data}, {1'b1, BOOT_NAK});
    repeat (6) @(negedge clk_sys);
    chk("ovr_req_held", {mem_req, mem_addr}, {1'b1, 32'h0});
    gnt_hold = 0;
    get_resp("ovr", d, lat);
    chk("ovr_resp", d, BOOT_NAK);
    repeat (3) @(negedge clk_sys);
    check_writes("ovr", exp1);
    chk("ovr_req_drop", mem_req, 0);
    wr_q.delete();

    // Timeout after 3 payload bytes
    make_frame(2, 0, q, exp);
    q = q[0:5];
    send_bytes(q, 0);
    get_resp("tmo", d, lat);
    chk("tmo_resp", d, BOOT_NAK); chk("tmo_lat", lat, TMO);

    // A byte arriving exactly at expiry is accepted
    make_frame(1, 0, q, exp);
    send_bytes(q[0:5], 0);
    repeat (TMO - 2) @(negedge clk_sys);
    send_byte(q[6]);
    chk("expiry_no_tx", tx_valid, 0);
    send_byte(q[7]);
    get_resp("expiry", d, lat);
    chk("expiry_resp", d, BOOT_ACK); chk("expiry_lat", lat, 1);
    check_writes("expiry", exp);
    check_status("expiry", 0, 1, 1);
    // RUN ignores RX
    wr_q.delete();
    send_bytes('{8'hA5, 8'h01, 8'h00, 8'h00}, 0);
    repeat (4) @(negedge clk_sys);
    chk("run_quiet", {tx_valid, mem_req, core_rst}, 3'b000);

    // Bad checksum then good resend
    do_reset();
    q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
          8'h55, 8'h66, 8'h77, 8'h88, 8'h65};
    exp = '{wr_t'{32'h0, 32'h4433_2211}, wr_t'{32'h4, 32'h8877_6655}};
    send_bytes(q, 0);
    get_resp("csbad", d, lat);
    chk("csbad_resp", d, BOOT_NAK);
    check_writes("csbad", exp);
    check_status("csbad", 1, 0, 1);
    wr_q.delete();
    q[11] = 8'h64;
    send_bytes(q, 0);
    get_resp("resend", d, lat);
    chk("resend_resp", d, BOOT_ACK);
    check_writes("resend", exp);
    check_status("resend", 0, 1, 1);

    // Reference frame with latency checks
    do_reset();
    send_bytes(q[0:6], 0);
    chk("w0_lat", {mem_req, mem_addr, mem_wdata}, {1'b1, 32'h0, 32'h4433_2211});
    send_bytes(q[7:10], 0);
    chk("w1_lat", {mem_req, mem_addr, mem_wdata}, {1'b1, 32'h4, 32'h8877_6655});
    send_byte(q[11]);
    get_resp("ok", d, lat);
    chk("ok_resp", d, BOOT_ACK); chk("ok_lat", lat, 1);
    check_writes("ok", exp);
    check_status("ok", 0, 1, 0);

    // Reset mid-DATA with a write pending
    do_reset();
    make_frame(2, 0, q, exp);
    gnt_hold = 1;
    send_bytes(q[0:7], 0);
    chk("mid_req", mem_req, 1);
    @(negedge clk_sys); #2 rst_sys = 1'b1; #1;
    check_reset_vals("mid_rst");
    gnt_hold = 0;
    repeat (3) @(negedge clk_sys);
    chk("mid_nwr", wr_q.size(), 0);
    rst_sys = 1'b0;
    make_frame(3, 0, q, exp);
    send_bytes(q, 0);
    get_resp("mid_boot", d, lat);
    chk("mid_boot_resp", d, BOOT_ACK);
    check_writes("mid_boot", exp);
    check_status("mid_boot", 0, 1, 0);

    // Randomized frames against the model
    do_reset();
    gnt_rand = 1; exp_err = 0;
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 3)) begin
        do g = 8'($urandom); while (g == 8'hA5);
        send_byte(g);
      end
      bad = ($urandom_range(0, 2) == 0);
      make_frame($urandom_range(1, 6), bad, q, exp);
      wr_q.delete();
      send_bytes(q, 3);
      get_resp("rnd", d, lat);
      chk("rnd_resp", d, bad ? BOOT_NAK : BOOT_ACK);
      check_writes("rnd", exp);
      if (bad) exp_err = 1;
      check_status("rnd", bad, !bad, exp_err);
      if (!bad) begin do_reset(); exp_err = 0; end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
